// File: rtl/vram_cpu_port.sv
// vram_cpu_port: CPU byte port onto the 32-bit VRAM slave bus, with an auto-stepping byte address.
// Build option: define VRAM_PORT_PREFETCH_EN to keep a prefetched read byte (zero-wait CPU reads).
`timescale 1ns/1ps
module vram_cpu_port #(
    parameter int VRAM_SIZE_BYTES = 131072
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        addr_set,
    input  logic [16:0] addr_set_data,
    input  logic [3:0]  incr_sel,
    input  logic        decr,
    input  logic        cpu_rd_strobe,
    input  logic        cpu_wr_strobe,
    input  logic [7:0]  cpu_wrdata,
    output logic [7:0]  cpu_rddata,
    output logic        busy,
    output logic        overrun,
    output logic        bus_strobe,
    input  logic        bus_ack,
    output logic [14:0] bus_addr,
    output logic [31:0] bus_wrdata,
    output logic [3:0]  bus_wrbytesel,
    output logic        bus_write,
    input  logic [31:0] bus_rddata
);

`ifdef VRAM_PORT_PREFETCH_EN
    localparam bit PREFETCH_EN = 1'b1;
`else
    localparam bit PREFETCH_EN = 1'b0;
`endif

    localparam logic [16:0] ADDR_MASK = 17'(VRAM_SIZE_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ_WRITE,
        S_REQ_READ,
        S_WAIT_DATA
    } state_t;

    state_t      r_state;
    logic [16:0] r_addr;
    logic [9:0]  r_step;
    logic        r_decr;
    logic [7:0]  r_rddata;
    logic        r_busy;
    logic        r_overrun;
    logic        r_bus_strobe;
    logic        r_bus_write;
    logic [14:0] r_bus_addr;
    logic [31:0] r_bus_wrdata;
    logic [3:0]  r_bus_wrbytesel;

    logic [16:0] w_addr_next;
    logic [16:0] w_set_addr;
    logic        w_any_strobe;

    function automatic logic [9:0] step_of(input logic [3:0] sel);
        logic [9:0] w_step;
        case (sel)
            4'd0:    w_step = 10'd0;
            4'd1:    w_step = 10'd1;
            4'd2:    w_step = 10'd2;
            4'd3:    w_step = 10'd4;
            4'd4:    w_step = 10'd8;
            4'd5:    w_step = 10'd16;
            4'd6:    w_step = 10'd32;
            4'd7:    w_step = 10'd64;
            4'd8:    w_step = 10'd128;
            4'd9:    w_step = 10'd256;
            4'd10:   w_step = 10'd512;
            4'd11:   w_step = 10'd40;
            4'd12:   w_step = 10'd80;
            4'd13:   w_step = 10'd160;
            4'd14:   w_step = 10'd320;
            default: w_step = 10'd640;
        endcase
        return w_step;
    endfunction

    // Carry/borrow out of bit 16 is dropped; the mask folds a 64K part onto 16 bits.
    function automatic logic [16:0] advance(input logic [16:0] a, input logic [9:0] s,
                                            input logic d);
        logic [16:0] w_sum;
        w_sum = d ? (a - {7'd0, s}) : (a + {7'd0, s});
        return w_sum & ADDR_MASK;
    endfunction

    function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [1:0] sel);
        logic [7:0] w_byte;
        case (sel)
            2'd0:    w_byte = w[7:0];
            2'd1:    w_byte = w[15:8];
            2'd2:    w_byte = w[23:16];
            default: w_byte = w[31:24];
        endcase
        return w_byte;
    endfunction

    assign w_addr_next  = advance(r_addr, r_step, r_decr);
    assign w_set_addr   = addr_set_data & ADDR_MASK;
    assign w_any_strobe = addr_set | cpu_wr_strobe | cpu_rd_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_addr          <= '0;
            r_step          <= '0;
            r_decr          <= 1'b0;
            r_rddata        <= '0;
            r_busy          <= 1'b0;
            r_overrun       <= 1'b0;
            r_bus_strobe    <= 1'b0;
            r_bus_write     <= 1'b0;
            r_bus_addr      <= '0;
            r_bus_wrdata    <= '0;
            r_bus_wrbytesel <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Priority: addr_set, then write, then read; losers are dropped silently.
                    if (addr_set) begin
                        r_addr    <= w_set_addr;
                        r_step    <= step_of(incr_sel);
                        r_decr    <= decr;
                        r_overrun <= 1'b0;
                        if (PREFETCH_EN) begin
                            r_state         <= S_REQ_READ;
                            r_busy          <= 1'b1;
                            r_bus_strobe    <= 1'b1;
                            r_bus_write     <= 1'b0;
                            r_bus_wrbytesel <= 4'b0000;
                            r_bus_addr      <= w_set_addr[16:2];
                        end
                    end else if (cpu_wr_strobe) begin
                        r_state         <= S_REQ_WRITE;
                        r_busy          <= 1'b1;
                        r_bus_strobe    <= 1'b1;
                        r_bus_write     <= 1'b1;
                        r_bus_addr      <= r_addr[16:2];
                        r_bus_wrdata    <= {4{cpu_wrdata}};
                        r_bus_wrbytesel <= 4'b0001 << r_addr[1:0];
                    end else if (cpu_rd_strobe) begin
                        r_state         <= S_REQ_READ;
                        r_busy          <= 1'b1;
                        r_bus_strobe    <= 1'b1;
                        r_bus_write     <= 1'b0;
                        r_bus_wrbytesel <= 4'b0000;
                        if (PREFETCH_EN) begin
                            r_addr     <= w_addr_next;
                            r_bus_addr <= w_addr_next[16:2];
                        end else begin
                            r_bus_addr <= r_addr[16:2];
                        end
                    end
                end

                S_REQ_WRITE: begin
                    if (bus_ack) begin
                        r_addr          <= w_addr_next;
                        r_bus_write     <= 1'b0;
                        r_bus_wrbytesel <= 4'b0000;
                        if (PREFETCH_EN) begin
                            r_state    <= S_REQ_READ;
                            r_bus_addr <= w_addr_next[16:2];
                        end else begin
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                            r_bus_strobe <= 1'b0;
                        end
                    end
                end

                S_REQ_READ: begin
                    if (bus_ack) begin
                        r_state      <= S_WAIT_DATA;
                        r_bus_strobe <= 1'b0;
                    end
                end

                S_WAIT_DATA: begin
                    // Without prefetch the CPU read consumes this byte, so step past it now.
                    r_rddata <= lane_of(bus_rddata, r_addr[1:0]);
                    if (!PREFETCH_EN) begin
                        r_addr <= w_addr_next;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_bus_strobe <= 1'b0;
                    r_bus_write  <= 1'b0;
                end
            endcase

            if (r_state != S_IDLE && w_any_strobe) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign cpu_rddata    = r_rddata;
    assign busy          = r_busy;
    assign overrun       = r_overrun;
    assign bus_strobe    = r_bus_strobe;
    assign bus_write     = r_bus_write;
    assign bus_addr      = r_bus_addr;
    assign bus_wrdata    = r_bus_wrdata;
    assign bus_wrbytesel = r_bus_wrbytesel;

endmodule
